// File: rtl/jk_selfcheck_driver.sv
// jk_selfcheck_driver: drives J/K stimulus into the JK flip-flop block and
// checks its SR-, D- and T-based outputs against a reference model.
module jk_selfcheck_driver #(
    parameter int unsigned NUM_VECTORS = 16,
    parameter logic [7:0]  SEED        = 8'hA5,
    parameter int unsigned ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic             Q_sr,
    input  logic             Q_d,
    input  logic             Q_t,
    output logic             J,
    output logic             K,
    output logic             dut_rst,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [2:0]       err_mask,
    output logic [7:0]       first_err_idx
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [7:0]       SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [7:0]       LAST_K   = 8'(NUM_VECTORS - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;
    localparam logic [7:0]       NO_ERR   = 8'hFF;

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    function automatic logic jk_next(input logic j, input logic k,
                                     input logic q);
        return (j & ~q) | (~k & q);
    endfunction

    state_t           state_q;
    logic             J_q;
    logic             K_q;
    logic             dut_rst_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic [ERR_W-1:0] err_cnt_q;
    logic [2:0]       err_mask_q;
    logic [7:0]       first_q;
    logic             exp_q;
    logic [7:0]       k_q;
    logic [7:0]       lfsr_q;
    logic             mode_q;

    logic [2:0]       mism_d;
    logic             any_mism;
    logic [ERR_W-1:0] err_cnt_d;
    logic [2:0]       err_mask_d;
    logic [7:0]       first_d;
    logic [1:0]       dir_idx;
    logic             vec_j;
    logic             vec_k;
    logic [7:0]       lfsr_d;
    logic [7:0]       k_d;
    logic             exp_d;

    always_comb begin
        mism_d     = {Q_t, Q_d, Q_sr} ^ {3{exp_q}};
        any_mism   = |mism_d;
        err_cnt_d  = err_cnt_q;
        if (any_mism && (err_cnt_q != ERR_MAX)) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end
        err_mask_d = err_mask_q | mism_d;
        first_d    = first_q;
        if (any_mism && (first_q == NO_ERR)) begin
            first_d = k_q;
        end
    end

    // INIT issues vector 0; each RUN edge issues the vector after k.
    always_comb begin
        dir_idx = (state_q == S_RUN) ? (k_q[1:0] + 2'd1) : k_q[1:0];
        if (mode_q) begin
            vec_j = dir_idx[1];
            vec_k = dir_idx[0];
        end else begin
            vec_j = lfsr_q[0];
            vec_k = lfsr_q[1];
        end
        lfsr_d = lfsr_step(lfsr_q);
        k_d    = k_q + 8'd1;
        exp_d  = jk_next(J_q, K_q, exp_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            J_q        <= 1'b0;
            K_q        <= 1'b0;
            dut_rst_q  <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_cnt_q  <= '0;
            err_mask_q <= '0;
            first_q    <= NO_ERR;
            exp_q      <= 1'b0;
            k_q        <= 8'd0;
            lfsr_q     <= SEED_EFF;
            mode_q     <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q    <= S_INIT;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        pass_q     <= 1'b0;
                        err_cnt_q  <= '0;
                        err_mask_q <= '0;
                        first_q    <= NO_ERR;
                        mode_q     <= mode;
                        lfsr_q     <= SEED_EFF;
                        dut_rst_q  <= 1'b1;
                        J_q        <= 1'b0;
                        K_q        <= 1'b0;
                        exp_q      <= 1'b0;
                        k_q        <= 8'd0;
                    end else if (state_q == S_IDLE) begin
                        dut_rst_q <= 1'b0;
                    end
                end
                S_INIT: begin
                    dut_rst_q <= 1'b0;
                    J_q       <= vec_j;
                    K_q       <= vec_k;
                    lfsr_q    <= lfsr_d;
                    state_q   <= S_RUN;
                end
                S_RUN: begin
                    err_cnt_q  <= err_cnt_d;
                    err_mask_q <= err_mask_d;
                    first_q    <= first_d;
                    exp_q      <= exp_d;
                    k_q        <= k_d;
                    if (k_q == LAST_K) begin
                        J_q     <= 1'b0;
                        K_q     <= 1'b0;
                        state_q <= S_FLUSH;
                    end else begin
                        J_q    <= vec_j;
                        K_q    <= vec_k;
                        lfsr_q <= lfsr_d;
                    end
                end
                S_FLUSH: begin
                    err_cnt_q  <= err_cnt_d;
                    err_mask_q <= err_mask_d;
                    first_q    <= first_d;
                    pass_q     <= (err_cnt_d == '0);
                    busy_q     <= 1'b0;
                    done_q     <= 1'b1;
                    state_q    <= S_DONE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign J             = J_q;
    assign K             = K_q;
    assign dut_rst       = dut_rst_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_cnt       = err_cnt_q;
    assign err_mask      = err_mask_q;
    assign first_err_idx = first_q;

endmodule

// File: tb/tb_jk_selfcheck_driver.sv
// Bench for jk_selfcheck_driver: JK flip-flop stand-ins with fault knobs,
// a run-level expectation model and directed runs.
`timescale 1ns/1ps
module tb_jk_selfcheck_driver;

    localparam int N = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       mode = 1'b1;
    logic       stuck_t = 1'b0;
    logic       inv_sr = 1'b0;
    logic       Q_sr, Q_d, Q_t;
    logic       J, K, dut_rst, busy, done, pass;
    logic [7:0] err_cnt;
    logic [2:0] err_mask;
    logic [7:0] first_err_idx;

    logic       start2 = 1'b0;
    logic       Q_sr2, Q_d2, Q_t2;
    logic       J2, K2, dut_rst2, busy2, done2, pass2;
    logic [1:0] err_cnt2;
    logic [2:0] err_mask2;
    logic [7:0] first2;

    jk_selfcheck_driver #(.NUM_VECTORS(N), .SEED(8'hA5), .ERR_W(8)) u_dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .Q_sr(Q_sr), .Q_d(Q_d), .Q_t(Q_t),
        .J(J), .K(K), .dut_rst(dut_rst), .busy(busy), .done(done),
        .pass(pass), .err_cnt(err_cnt), .err_mask(err_mask),
        .first_err_idx(first_err_idx)
    );

    jk_selfcheck_driver #(.NUM_VECTORS(N), .SEED(8'hA5), .ERR_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .mode(1'b1),
        .Q_sr(Q_sr2), .Q_d(Q_d2), .Q_t(Q_t2),
        .J(J2), .K(K2), .dut_rst(dut_rst2), .busy(busy2), .done(done2),
        .pass(pass2), .err_cnt(err_cnt2), .err_mask(err_mask2),
        .first_err_idx(first2)
    );

    // Behavioural JK flip-flops standing in for the checked block.
    logic q_ff, q2_ff;
    always_ff @(posedge clk) begin
        if (dut_rst) q_ff <= 1'b0;
        else if (J && K) q_ff <= ~q_ff;
        else if (J) q_ff <= 1'b1;
        else if (K) q_ff <= 1'b0;
    end
    always_ff @(posedge clk) begin
        if (dut_rst2) q2_ff <= 1'b0;
        else if (J2 && K2) q2_ff <= ~q2_ff;
        else if (J2) q2_ff <= 1'b1;
        else if (K2) q2_ff <= 1'b0;
    end
    assign Q_sr  = q_ff ^ inv_sr;
    assign Q_d   = q_ff;
    assign Q_t   = stuck_t ? 1'b0 : q_ff;
    assign Q_sr2 = ~q2_ff;
    assign Q_d2  = q2_ff;
    assign Q_t2  = q2_ff;

    int n_vec = 0;
    int n_mis = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- expectation model ----------------
    int         t = -2;   // edges since the accepted start; -1 idle after reset
    logic       rst_prev = 1'b1;
    logic [1:0] vec [N];  // {J,K} per vector
    int         e_err;
    logic [2:0] e_mask;
    logic [7:0] e_first;

    function automatic logic [7:0] lfsr_adv(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    task automatic build();
        logic [7:0] s;
        int         q;
        int         cnt;
        logic [2:0] got;
        logic [2:0] mism;
        s = 8'hA5;
        for (int i = 0; i < N; i++) begin
            if (mode) begin
                vec[i] = 2'(i % 4);
            end else begin
                vec[i] = {s[0], s[1]};
                s = lfsr_adv(s);
            end
        end
        q = 0; cnt = 0; e_mask = 3'b000; e_first = 8'hFF;
        for (int k = 0; k <= N; k++) begin
            got  = {(stuck_t ? 1'b0 : 1'(q)), 1'(q), 1'(q) ^ inv_sr};
            mism = got ^ {3{1'(q)}};
            if (mism != 3'b000) begin
                cnt++;
                e_mask |= mism;
                if (e_first == 8'hFF) e_first = 8'(k);
            end
            if (k < N) begin
                if (vec[k] == 2'b11) q = 1 - q;
                else if (vec[k] == 2'b10) q = 1;
                else if (vec[k] == 2'b01) q = 0;
            end
        end
        e_err = (cnt > 255) ? 255 : cnt;
    endtask

    always @(posedge clk) begin
        if (rst) t = -1;
        else if ((t == -1 || t >= N + 2) && start) begin
            build();
            t = 0;
        end else if (t >= 0 && t < N + 2) t++;
        rst_prev = rst;
    end

    always @(negedge clk) begin
        if (t == -1) begin
            chk("idle_jk", {J, K}, 2'b00);
            chk("idle_dut_rst", dut_rst, rst_prev);
            chk("idle_busy_done", {busy, done, pass}, 3'b000);
            chk("idle_err", err_cnt, 0);
            chk("idle_mask", err_mask, 0);
            chk("idle_first", first_err_idx, 8'hFF);
        end else if (t == 0) begin
            chk("start_jk_rst", {J, K, dut_rst}, 3'b001);
            chk("start_busy_done", {busy, done, pass}, 3'b100);
            chk("start_err_clr", err_cnt, 0);
            chk("start_mask_clr", err_mask, 0);
            chk("start_first_clr", first_err_idx, 8'hFF);
        end else if (t >= 1 && t <= N) begin
            chk("run_jk", {J, K}, vec[t-1]);
            chk("run_ctl", {dut_rst, busy, done}, 3'b010);
        end else if (t == N + 1) begin
            chk("flush_jk", {J, K}, 2'b00);
            chk("flush_ctl", {dut_rst, busy, done}, 3'b010);
        end else if (t >= N + 2) begin
            chk("done_jk", {J, K}, 2'b00);
            chk("done_ctl", {dut_rst, busy, done}, 3'b001);
            chk("done_err", err_cnt, e_err);
            chk("done_mask", err_mask, e_mask);
            chk("done_first", first_err_idx, e_first);
            chk("done_pass", pass, (e_err == 0));
        end
    end

    // ---------------- stimulus ----------------
    logic [1:0] tr [2][N+2];

    task automatic pulse_start(input logic m);
        mode  = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_edges);
        int e;
        e = 0;
        while (!done && e < 40) begin
            @(negedge clk);
            e++;
        end
        chk(name, e, exp_edges);
    endtask

    task automatic capture(input int w);
        for (int i = 0; i < N + 2; i++) begin
            tr[w][i] = {J, K};
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_dut_rst", dut_rst, 1'b1);
        chk("reset_first", first_err_idx, 8'hFF);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Directed walk, ideal block.
        pulse_start(1'b1);
        chk("model_vec2_set", vec[2], 2'b10);
        wait_done("dir_done_edges", 10);
        chk("dir_pass", pass, 1'b1);
        chk("dir_err", err_cnt, 0);
        chk("dir_first", first_err_idx, 8'hFF);

        // Back-to-back, Q_t stuck low.
        stuck_t = 1'b1;
        pulse_start(1'b1);
        chk("b2b_done_drop", done, 1'b0);
        wait_done("stuck_done_edges", 10);
        chk("stuck_err", err_cnt, 2);
        chk("stuck_mask", err_mask, 3'b100);
        chk("stuck_first", first_err_idx, 3);
        chk("stuck_pass", pass, 1'b0);
        stuck_t = 1'b0;

        // Back-to-back again, errors from previous run must clear.
        pulse_start(1'b1);
        chk("b2b_err_clr", err_cnt, 0);
        wait_done("clr_done_edges", 10);
        chk("clr_pass", pass, 1'b1);

        // LFSR mode twice, traces must repeat.
        pulse_start(1'b0);
        chk("model_lfsr_v0", vec[0], 2'b10);
        chk("model_lfsr_v1", vec[1], 2'b01);
        chk("model_lfsr_v2", vec[2], 2'b10);
        chk("model_lfsr_v3", vec[3], 2'b01);
        capture(0);
        wait_done("lfsr_done_edges", 0);
        chk("lfsr_pass", pass, 1'b1);
        pulse_start(1'b0);
        capture(1);
        wait_done("lfsr2_done_edges", 0);
        for (int i = 0; i < N + 2; i++) chk("lfsr_rerun_trace", tr[1][i], tr[0][i]);

        // start held through the run, reset on the 4th RUN edge.
        inv_sr = 1'b1;
        mode   = 1'b1;
        start  = 1'b1;
        repeat (5) @(negedge clk);
        chk("abort_pre_err", (err_cnt != 0), 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_jk_rst", {J, K, dut_rst}, 3'b001);
        chk("abort_busy_done", {busy, done, pass}, 3'b000);
        chk("abort_err", err_cnt, 0);
        chk("abort_mask", err_mask, 0);
        chk("abort_first", first_err_idx, 8'hFF);
        rst    = 1'b0;
        start  = 1'b0;
        inv_sr = 1'b0;
        repeat (2) @(negedge clk);

        // ERR_W=2 instance with Q_sr inverted: counter saturates.
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        begin
            int e;
            e = 0;
            while (!done2 && e < 40) begin
                @(negedge clk);
                e++;
            end
            chk("sat_done_edges", e, 10);
        end
        chk("sat_err", err_cnt2, 2'd3);
        chk("sat_mask", err_mask2, 3'b001);
        chk("sat_first", first2, 8'd0);
        chk("sat_pass", pass2, 1'b0);
        @(negedge clk);
        chk("sat_hold", err_cnt2, 2'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/jk_selfcheck_driver.md
Name: jk_selfcheck_driver

Overview:
- Self-checking stimulus/response stage that wraps the JK flip-flop block from both sides.
- Upstream role: generates the J/K excitation sequence and the block reset.
- Downstream role: consumes the three implementation outputs Q_sr, Q_d and Q_t, compares each against an internal JK reference model, and reports pass/fail, error count and first-failure index.
- Used for on-chip equivalence checking of the SR-, D- and T-based JK implementations.

Parameters:
- NUM_VECTORS, 16, number of J/K vectors applied per run (1..255).
- SEED, 8'hA5, LFSR seed; a value of 0 is replaced by 8'h01.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle run request; sampled only in IDLE and DONE.
- mode  in  1  0 = LFSR vectors, 1 = directed walk 00,01,10,11 repeating; sampled at start.
- Q_sr  in  1  DUT output, SR-based implementation.
- Q_d  in  1  DUT output, D-based implementation.
- Q_t  in  1  DUT output, T-based implementation.
- J  out  1  registered excitation to DUT.
- K  out  1  registered excitation to DUT.
- dut_rst  out  1  registered synchronous reset to DUT.
- busy  out  1  high in INIT, RUN and FLUSH.
- done  out  1  high in DONE.
- pass  out  1  done && err_cnt==0.
- err_cnt  out  ERR_W  mismatching comparisons; saturates at all-ones.
- err_mask  out  3  sticky per-implementation mismatch flags {Q_t,Q_d,Q_sr}.
- first_err_idx  out  8  comparison index k of the first mismatch; 8'hFF if none.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high, with priority over all other inputs, including mid-run.
- Reset values:
  - state=IDLE; J=K=0; dut_rst=1.
  - busy=done=pass=0; err_cnt=0; err_mask=0; first_err_idx=8'hFF.
  - exp_q=0; k=0; lfsr=SEED.
- dut_rst deasserts (0) on the first edge in IDLE after reset.
- JK reference model: exp_q_next = J&~Q | ~K&Q (00 hold, 01 clear, 10 set, 11 toggle).
- LFSR: 8-bit Fibonacci. Shift left; new bit0 = b7^b5^b4^b3. Advances once per applied vector. Vector = {J=b0, K=b1}.
- Directed mode: vector k = {J,K} = k[1:0] encoded as 00,01,10,11.
- FSM: IDLE -> INIT -> RUN -> FLUSH -> DONE.
  - IDLE/DONE, start=1: go to INIT. Clear err_cnt/err_mask/first_err_idx and done; latch mode; load lfsr=SEED; set dut_rst=1, J=K=0, exp_q=0, k=0.
  - INIT (exactly 1 cycle): the DUT samples its reset on this edge. Set dut_rst=0, drive vector 0 on J/K, go to RUN.
  - RUN, every edge:
    - Compare Q_sr/Q_d/Q_t against exp_q. This is comparison k (the state after k vectors).
    - Update exp_q from the current J/K (vector k being applied).
    - k<=k+1; drive vector k+1.
    - When k==NUM_VECTORS-1: drive J=K=0 and go to FLUSH.
  - FLUSH (1 cycle): compare k=NUM_VECTORS, then go to DONE. J=K=0 holds the DUT state.
  - DONE: hold all results until start or rst.
- Comparison result update (each comparing edge):
  - Any bit differs: err_cnt++ (saturating).
  - err_mask |= per-implementation mismatch bits.
  - If first_err_idx==8'hFF, capture k.
- Timing:
  - start sampled at edge e0; done rises after edge e0+NUM_VECTORS+2.
  - NUM_VECTORS+1 comparisons are made; comparison k=0 checks the post-reset state (Q=0).
- Boundary conditions:
  - start while busy: ignored.
  - start in DONE: immediate restart.
  - NUM_VECTORS=1: RUN lasts one cycle.
  - err_cnt at all-ones stays at all-ones.
  - rst mid-run aborts the run and also asserts dut_rst.

Test Plan:
- Ideal DUT model, mode=1, NUM_VECTORS=8, start pulse -> J/K sequence 00,01,10,11,00,01,10,11; expected Q after each vector 0,0,1,0,0,0,1,0; done after 10 edges; pass=1, err_cnt=0, first_err_idx=8'hFF.
- Same setup with Q_t stuck at 0 -> err_cnt=2, err_mask=3'b100, first_err_idx=3, pass=0.
- mode=0, SEED=8'hA5, ideal DUT -> J/K match the LFSR bits every cycle (bench-modelled); pass=1. Rerun with identical start -> identical J/K trace.
- ERR_W=2, Q_sr inverted, NUM_VECTORS=8 -> err_cnt saturates at 3, err_mask=3'b001, first_err_idx=0.
- start held high during RUN, then rst asserted at the 4th RUN cycle -> start ignored while busy; next edge gives IDLE, J=K=0, dut_rst=1, all results at reset values.
- Back-to-back: start in DONE -> done drops next edge, err_cnt cleared, new run completes.
